mod_dp_unit: RTL and testbench

MOD_DP_UNIT -- requirements
Module: mod_dp_unit

---
 rtl/mod_dp_unit_if.sv | 31 +++
 rtl/mod_dp_unit.sv | 93 +++++++++
 tb/tb_mod_dp_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mod_dp_unit_if.sv
// Operation bus for the modulo datapath: requester handshake, control-FSM
// strobes, and the results returned to both.
interface mod_dp_unit_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         asg_tempp;
    logic         make_sub;
    logic         make_asg;
    logic         make_comp;
    logic         done;
    logic         lt;
    logic         cu_reset;
    logic         busy;
    logic [W-1:0] result;
    logic [W-1:0] quotient;
    logic         result_valid;
    logic         div_zero;

    modport master (
        output start, a_in, b_in, asg_tempp, make_sub, make_asg, make_comp, done,
        input  lt, cu_reset, busy, result, quotient, result_valid, div_zero
    );

    modport slave (
        input  start, a_in, b_in, asg_tempp, make_sub, make_asg, make_comp, done,
        output lt, cu_reset, busy, result, quotient, result_valid, div_zero
    );
endinterface

// File: rtl/mod_dp_unit.sv
// Modulo/divide datapath by repeated subtraction, sequenced by an external
// control FSM through strobes; divide-by-zero is answered directly from IDLE.
module mod_dp_unit #(
    parameter int unsigned W = 8
) (
    input  logic          CLK,
    input  logic          reset,
    mod_dp_unit_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e       state_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] temp_q;
    logic [W-1:0] diff_q;
    logic [W-1:0] qcnt_q;
    logic [W-1:0] result_q;
    logic [W-1:0] quot_q;
    logic         rv_q;
    logic         dz_q;

    logic         run_c;
    logic         ge_c;
    logic [W-1:0] diff_d;
    logic [W-1:0] qcnt_d;

    assign run_c  = (state_q == RUN);
    assign ge_c   = (temp_q >= b_q);
    // Subtraction saturates: below the divisor the value passes through unchanged.
    assign diff_d = ge_c ? W'(temp_q - b_q) : temp_q;
    assign qcnt_d = ge_c ? W'(qcnt_q + W'(1)) : qcnt_q;

    assign bus.busy         = run_c;
    assign bus.cu_reset     = ~run_c;
    assign bus.lt           = ~ge_c;
    assign bus.result       = result_q;
    assign bus.quotient     = quot_q;
    assign bus.result_valid = rv_q;
    assign bus.div_zero     = dz_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            temp_q   <= '0;
            diff_q   <= '0;
            qcnt_q   <= '0;
            result_q <= '0;
            quot_q   <= '0;
            rv_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.b_in != '0) begin
                            a_q     <= bus.a_in;
                            b_q     <= bus.b_in;
                            qcnt_q  <= '0;
                            state_q <= RUN;
                        end else begin
                            result_q <= bus.a_in;
                            quot_q   <= '0;
                            dz_q     <= 1'b1;
                            rv_q     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.asg_tempp) begin
                        temp_q <= a_q;
                    end else if (bus.make_sub) begin
                        diff_q <= diff_d;
                        qcnt_q <= qcnt_d;
                    end else if (bus.make_asg) begin
                        temp_q <= diff_q;
                    end else if (bus.done) begin
                        result_q <= temp_q;
                        quot_q   <= qcnt_q;
                        dz_q     <= 1'b0;
                        rv_q     <= 1'b1;
                        state_q  <= IDLE;
                    end else if (bus.make_comp) begin
                        // lt is decoded combinationally; nothing to store here
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mod_dp_unit.sv
// Scoreboard bench for mod_dp_unit, with a behavioural control FSM driving
// the strobes (INIT, then SUB/ASG/COMP loop until lt, then DONE).
module tb_mod_dp_unit;
    localparam int unsigned W = 8;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    mod_dp_unit_if #(.W(W)) bus ();

    mod_dp_unit #(.W(W)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    // Control FSM model: synchronously held in INIT by cu_reset.
    typedef enum logic [2:0] {C_INIT, C_SUB, C_ASG, C_COMP, C_DONE} cst_e;
    cst_e cst;
    always_ff @(posedge CLK) begin
        if (bus.cu_reset) cst <= C_INIT;
        else begin
            case (cst)
                C_INIT:  cst <= C_SUB;
                C_SUB:   cst <= C_ASG;
                C_ASG:   cst <= C_COMP;
                C_COMP:  cst <= bus.lt ? C_DONE : C_SUB;
                default: cst <= C_INIT;
            endcase
        end
    end
    assign bus.asg_tempp = (cst == C_INIT);
    assign bus.make_sub  = (cst == C_SUB);
    assign bus.make_asg  = (cst == C_ASG);
    assign bus.make_comp = (cst == C_COMP);
    assign bus.done      = (cst == C_DONE);

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] quo;
        logic         dz;
        int           lat;
        int           t0;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one start cycle; push the expectation only when it should be accepted.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        int   k;
        @(negedge CLK);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        if (push) begin
            if (b == '0) begin
                e.res = a;
                e.quo = '0;
                e.dz  = 1'b1;
                e.lat = 0;
            end else begin
                e.res = a % b;
                e.quo = a / b;
                e.dz  = 1'b0;
                k     = (e.quo == '0) ? 1 : int'(e.quo);
                e.lat = 3 * k + 2;
            end
            e.t0 = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    always @(negedge CLK) begin
        if (reset === 1'b1 && bus.result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rv", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",   64'(bus.result),   64'(e.res));
                chk("quotient", 64'(bus.quotient), 64'(e.quo));
                chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
                chk("latency",  64'(cyc - e.t0),   64'(e.lat));
            end
        end
    end

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (3) @(negedge CLK);
        chk("rst_busy",     64'(bus.busy),         64'd0);
        chk("rst_cu_reset", 64'(bus.cu_reset),     64'd1);
        chk("rst_lt",       64'(bus.lt),           64'd0);
        chk("rst_result",   64'(bus.result),       64'd0);
        chk("rst_quotient", 64'(bus.quotient),     64'd0);
        chk("rst_rv",       64'(bus.result_valid), 64'd0);
        chk("rst_dz",       64'(bus.div_zero),     64'd0);
        reset = 1'b1;
        repeat (2) @(negedge CLK);

        issue(8'd23, 8'd5, 1'b1);
        @(negedge CLK);
        chk("busy_run", 64'(bus.busy), 64'd1);
        drain(100);
        repeat (3) @(negedge CLK);
        chk("result_hold", 64'(bus.result), 64'd3);

        issue(8'd3, 8'd5, 1'b1);
        drain(100);

        issue(8'd10, 8'd5, 1'b1);
        drain(100);
        issue(8'd17, 8'd4, 1'b1);
        drain(100);

        issue(8'd7, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("dz_busy", 64'(bus.busy), 64'd0);
            @(negedge CLK);
        end
        drain(10);

        issue(8'd0, 8'd3, 1'b1);
        drain(100);
        issue(8'd255, 8'd255, 1'b1);
        drain(100);

        for (int i = 0; i < 5; i++) begin
            issue(W'($urandom_range(0, 255)), W'($urandom_range(1, 20)), 1'b1);
            drain(1000);
        end

        // Abort a long run: ignored restart while busy, then async reset.
        issue(8'd255, 8'd1, 1'b1);
        repeat (10) @(negedge CLK);
        chk("busy_long", 64'(bus.busy), 64'd1);
        issue(8'd9, 8'd3, 1'b0);
        repeat (50) @(negedge CLK);
        chk("busy_before_abort", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        sb.delete();
        chk("abort_busy",     64'(bus.busy),         64'd0);
        chk("abort_cu_reset", 64'(bus.cu_reset),     64'd1);
        chk("abort_lt",       64'(bus.lt),           64'd0);
        chk("abort_result",   64'(bus.result),       64'd0);
        chk("abort_quotient", 64'(bus.quotient),     64'd0);
        chk("abort_rv",       64'(bus.result_valid), 64'd0);
        chk("abort_dz",       64'(bus.div_zero),     64'd0);
        @(negedge CLK);
        reset = 1'b1;
        repeat (20) @(negedge CLK);
        chk("post_abort_busy", 64'(bus.busy), 64'd0);

        issue(8'd255, 8'd1, 1'b1);
        drain(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
